// File: rtl/llmint8_sched_pkg.sv
// Shared types and width helpers for the int8 linear-layer scheduler.
package llmint8_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // Width of an index into x items; never narrower than one bit.
  function automatic int clog2_min1(input int x);
    return ($clog2(x) < 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/llmint8_credit_counter.sv
// Saturating up/down credit counter with full/empty flags and underflow detect.
module llmint8_credit_counter
  import llmint8_sched_pkg::*;
#(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = clog2_min1(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic full_nxt,
  output logic underflow
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             inc_ok_s;
  logic             dec_ok_s;

  assign full      = (count_r == CNT_W'(MAX_COUNT));
  assign empty     = (count_r == '0);
  assign full_nxt  = (count_nxt_s == CNT_W'(MAX_COUNT));
  // A decrement with nothing outstanding is flagged and otherwise ignored.
  assign underflow = dec & empty;

  // Next count: saturate at both ends, simultaneous inc/dec cancel out.
  always_comb begin
    inc_ok_s    = inc & ~full;
    dec_ok_s    = dec & ~empty;
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = '0;
    end else if (inc_ok_s && !dec_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (dec_ok_s && !inc_ok_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Credit count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/llmint8_linear_scheduler.sv
// Command sequencer for the int8 dequantizing linear datapath: walks
// rows x output blocks x input tiles, throttles open output blocks with a
// credit counter, and counts returned results to detect layer completion.
module llmint8_linear_scheduler
  import llmint8_sched_pkg::*;
#(
  parameter int IN_DEPTH        = 4,
  parameter int OUT_DEPTH       = 8,
  parameter int ROW_W           = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ACT_ADDR_W      = ROW_W + clog2_min1(IN_DEPTH),
  parameter int W_ADDR_W        = clog2_min1(OUT_DEPTH * IN_DEPTH),
  parameter int B_ADDR_W        = clog2_min1(OUT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_W-1:0]      cfg_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ACT_ADDR_W-1:0] cmd_act_addr,
  output logic [W_ADDR_W-1:0]   cmd_weight_addr,
  output logic [B_ADDR_W-1:0]   cmd_bias_addr,
  output logic                  cmd_first,
  output logic                  cmd_last,
  input  logic                  result_valid,
  input  logic                  result_ready
);

  localparam int TILE_W = clog2_min1(IN_DEPTH);
  localparam int CMP_W  = ROW_W + B_ADDR_W + 1;

  sched_state_t          state_r;
  logic [ROW_W-1:0]      rows_r;
  logic [ROW_W-1:0]      row_r;
  logic [TILE_W-1:0]     tile_r;
  logic [ACT_ADDR_W-1:0] act_base_r;
  logic [CMP_W-1:0]      done_cnt_r;
  logic [CMP_W-1:0]      target_r;
  logic                  busy_r, done_r, err_r, cmd_valid_r, cmd_first_r, cmd_last_r;
  logic [ACT_ADDR_W-1:0] cmd_act_addr_r;
  logic [W_ADDR_W-1:0]   cmd_weight_addr_r;
  logic [B_ADDR_W-1:0]   cmd_bias_addr_r;

  logic                  hs_s, res_hs_s, res_counted_s, accept_s;
  logic                  last_tile_s, last_blk_s, last_row_s, first_nxt_s, last_nxt_s;
  logic [TILE_W-1:0]     tile_nxt_s;
  logic [B_ADDR_W-1:0]   blk_nxt_s;
  logic [ROW_W-1:0]      row_nxt_s;
  logic [ACT_ADDR_W-1:0] act_base_nxt_s;
  logic [W_ADDR_W-1:0]   w_nxt_s;
  logic [CMP_W-1:0]      done_cnt_nxt_s;
  logic                  cred_inc_s, cred_full_s, cred_empty_s, cred_full_nxt_s, cred_underflow_s;

  assign hs_s           = cmd_valid_r & cmd_ready;
  assign res_hs_s       = result_valid & result_ready;
  assign res_counted_s  = res_hs_s & ~cred_empty_s;
  assign accept_s       = (state_r == ST_IDLE) & start;
  assign cred_inc_s     = hs_s & cmd_first_r & ~cred_full_s;
  assign done_cnt_nxt_s = done_cnt_r + CMP_W'(res_counted_s);

  llmint8_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_s),
    .inc       (cred_inc_s),
    .dec       (res_hs_s),
    .full      (cred_full_s),
    .empty     (cred_empty_s),
    .full_nxt  (cred_full_nxt_s),
    .underflow (cred_underflow_s)
  );

  // Next beat position; bases step by IN_DEPTH so no multiplier is needed.
  always_comb begin
    last_tile_s    = (tile_r == TILE_W'(IN_DEPTH - 1));
    last_blk_s     = (cmd_bias_addr_r == B_ADDR_W'(OUT_DEPTH - 1));
    last_row_s     = (row_r == rows_r - ROW_W'(1));
    tile_nxt_s     = last_tile_s ? '0 : tile_r + TILE_W'(1);
    blk_nxt_s      = cmd_bias_addr_r;
    row_nxt_s      = row_r;
    act_base_nxt_s = act_base_r;
    w_nxt_s        = cmd_weight_addr_r + W_ADDR_W'(1);
    if (last_tile_s) begin
      if (last_blk_s) begin
        blk_nxt_s      = '0;
        row_nxt_s      = row_r + ROW_W'(1);
        act_base_nxt_s = act_base_r + ACT_ADDR_W'(IN_DEPTH);
        w_nxt_s        = '0;
      end else begin
        blk_nxt_s      = cmd_bias_addr_r + B_ADDR_W'(1);
      end
    end else begin
      blk_nxt_s      = cmd_bias_addr_r;
    end
    first_nxt_s = (tile_nxt_s == '0);
    last_nxt_s  = (tile_nxt_s == TILE_W'(IN_DEPTH - 1));
  end

  // Control FSM with registered status and command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= ST_IDLE;
      rows_r            <= '0;
      row_r             <= '0;
      tile_r            <= '0;
      act_base_r        <= '0;
      done_cnt_r        <= '0;
      target_r          <= '0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      err_r             <= 1'b0;
      cmd_valid_r       <= 1'b0;
      cmd_first_r       <= 1'b0;
      cmd_last_r        <= 1'b0;
      cmd_act_addr_r    <= '0;
      cmd_weight_addr_r <= '0;
      cmd_bias_addr_r   <= '0;
    end else begin
      done_r     <= 1'b0;
      done_cnt_r <= done_cnt_nxt_s;
      if (cred_underflow_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rows_r            <= cfg_rows;
            target_r          <= CMP_W'(cfg_rows) * CMP_W'(OUT_DEPTH);
            err_r             <= 1'b0;
            busy_r            <= 1'b1;
            done_cnt_r        <= '0;
            row_r             <= '0;
            tile_r            <= '0;
            act_base_r        <= '0;
            cmd_act_addr_r    <= '0;
            cmd_weight_addr_r <= '0;
            cmd_bias_addr_r   <= '0;
            cmd_first_r       <= 1'b1;
            cmd_last_r        <= (IN_DEPTH == 1);
            if (cfg_rows == '0) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              cmd_valid_r <= 1'b0;
            end else begin
              state_r     <= ST_ISSUE;
              cmd_valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hs_s) begin
            if (last_tile_s && last_blk_s && last_row_s) begin
              state_r     <= ST_DRAIN;
              cmd_valid_r <= 1'b0;
            end else begin
              tile_r            <= tile_nxt_s;
              row_r             <= row_nxt_s;
              act_base_r        <= act_base_nxt_s;
              cmd_act_addr_r    <= act_base_nxt_s + ACT_ADDR_W'(tile_nxt_s);
              cmd_weight_addr_r <= w_nxt_s;
              cmd_bias_addr_r   <= blk_nxt_s;
              cmd_first_r       <= first_nxt_s;
              cmd_last_r        <= last_nxt_s;
              // A new block waits for a free credit; continuation beats never do.
              cmd_valid_r       <= ~(first_nxt_s & cred_full_nxt_s);
            end
          end else if (!cmd_valid_r) begin
            cmd_valid_r <= ~(cmd_first_r & cred_full_nxt_s);
          end else begin
            cmd_valid_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (done_cnt_nxt_s == target_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign err             = err_r;
  assign cmd_valid       = cmd_valid_r;
  assign cmd_act_addr    = cmd_act_addr_r;
  assign cmd_weight_addr = cmd_weight_addr_r;
  assign cmd_bias_addr   = cmd_bias_addr_r;
  assign cmd_first       = cmd_first_r;
  assign cmd_last        = cmd_last_r;

endmodule
